// File: rtl/cnu_float_min_sort_if.sv
// Message/result bundle for the serial check-node minimum sorter.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised it stays high, with its payload
// unchanged, until that transfer happens. Ready may be raised or dropped
// freely and never depends combinationally on valid.
interface cnu_float_min_sort_if #(
  parameter int DEG   = 6,
  parameter int EXP_W = 7,
  parameter int MAN_W = 10,
  parameter int IDX_W = 3
);
  // Input message stream from the fixed-to-float converter.
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;

  // Sorted result toward the check-to-variable update stage.
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_min1_exp;
  logic [MAN_W-1:0] out_min1_man;
  logic [EXP_W-1:0] out_min2_exp;
  logic [MAN_W-1:0] out_min2_man;
  logic [IDX_W-1:0] out_min1_idx;
  logic             out_sign_prod;
  logic [DEG-1:0]   out_sign_vec;

  // Producer of messages and consumer of results.
  modport master (
    output in_valid, in_sign, in_exp, in_man, out_ready,
    input  in_ready, out_valid, out_min1_exp, out_min1_man,
           out_min2_exp, out_min2_man, out_min1_idx,
           out_sign_prod, out_sign_vec
  );

  // The sorter itself.
  modport slave (
    input  in_valid, in_sign, in_exp, in_man, out_ready,
    output in_ready, out_valid, out_min1_exp, out_min1_man,
           out_min2_exp, out_min2_man, out_min1_idx,
           out_sign_prod, out_sign_vec
  );
endinterface

// File: rtl/cnu_float_min_sort.sv
// Serial check-node minimum sorter for the min-sum LDPC decoder.
// Accumulates DEG float-coded messages and then holds min1, min2, the
// index of min1, the sign product and the per-edge sign vector until the
// downstream stage takes them.
module cnu_float_min_sort #(
  parameter int DEG   = 6,
  parameter int EXP_W = 7,
  parameter int MAN_W = 10,
  parameter int IDX_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  cnu_float_min_sort_if.slave bus,
  output logic                o_dbg_state
);
  localparam int KEY_W = EXP_W + MAN_W;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_min1;
  logic [KEY_W-1:0] r_min2;
  logic [IDX_W-1:0] r_idx;
  logic             r_sign_prod;
  logic [DEG-1:0]   r_sign_vec;

  // Magnitude key: exponent above mantissa, compared unsigned; sign excluded.
  logic [KEY_W-1:0] w_key;
  logic             w_last;
  assign w_key  = {bus.in_exp, bus.in_man};
  assign w_last = (r_cnt == IDX_W'(DEG - 1));

  // Single state machine: accumulate beats, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_min1      <= '0;
      r_min2      <= '0;
      r_idx       <= '0;
      r_sign_prod <= 1'b0;
      r_sign_vec  <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            r_sign_vec[r_cnt] <= bus.in_sign;
            if (r_cnt == '0) begin
              // First edge seeds min1; min2 starts saturated.
              r_min1      <= w_key;
              r_min2      <= '1;
              r_idx       <= '0;
              r_sign_prod <= bus.in_sign;
            end else begin
              r_sign_prod <= r_sign_prod ^ bus.in_sign;
              // Strict less-than keeps the earliest edge on ties.
              if (w_key < r_min1) begin
                r_min2 <= r_min1;
                r_min1 <= w_key;
                r_idx  <= r_cnt;
              end else if (w_key < r_min2) begin
                r_min2 <= w_key;
              end
            end
            if (w_last) begin
              r_state <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= ST_ACCUM;
            r_cnt       <= '0;
            r_sign_prod <= 1'b0;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_HOLD);

  assign bus.out_min1_exp  = r_min1[KEY_W-1:MAN_W];
  assign bus.out_min1_man  = r_min1[MAN_W-1:0];
  assign bus.out_min2_exp  = r_min2[KEY_W-1:MAN_W];
  assign bus.out_min2_man  = r_min2[MAN_W-1:0];
  assign bus.out_min1_idx  = r_idx;
  assign bus.out_sign_prod = r_sign_prod;
  assign bus.out_sign_vec  = r_sign_vec;

  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_cnu_float_min_sort.sv
// Bench for cnu_float_min_sort: scenario tasks drive nodes, a reference
// model pushes expected results, a monitor pops them when out_valid rises.
module tb_cnu_float_min_sort;
  localparam int DEG   = 6;
  localparam int EXP_W = 7;
  localparam int MAN_W = 10;
  localparam int IDX_W = 3;
  localparam int KEY_W = EXP_W + MAN_W;
  localparam int RW    = 2 * KEY_W + IDX_W + 1 + DEG;

  logic clk;
  logic rst;
  logic dbg_state;

  cnu_float_min_sort_if #(.DEG(DEG), .EXP_W(EXP_W), .MAN_W(MAN_W), .IDX_W(IDX_W)) bus ();

  cnu_float_min_sort #(.DEG(DEG), .EXP_W(EXP_W), .MAN_W(MAN_W), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [RW-1:0]    exp_q[$];
  logic [RW-1:0]    last_exp;
  logic             prev_v = 1'b0;

  logic             m_sign [DEG];
  logic [EXP_W-1:0] m_exp  [DEG];
  logic [MAN_W-1:0] m_man  [DEG];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] got_result();
    return {bus.out_min1_exp, bus.out_min1_man, bus.out_min2_exp, bus.out_min2_man,
            bus.out_min1_idx, bus.out_sign_prod, bus.out_sign_vec};
  endfunction

  // Reference: min1 is the earliest smallest key, min2 the smallest of the rest.
  function automatic logic [RW-1:0] model();
    logic [KEY_W-1:0] k, k1, k2;
    int               i1;
    logic             sp;
    logic [DEG-1:0]   sv;
    k1 = '1; i1 = 0; sp = 1'b0; sv = '0;
    for (int i = 0; i < DEG; i++) begin
      k = {m_exp[i], m_man[i]};
      if (i == 0 || k < k1) begin k1 = k; i1 = i; end
      sp = sp ^ m_sign[i];
      sv[i] = m_sign[i];
    end
    k2 = '1;
    for (int i = 0; i < DEG; i++) begin
      k = {m_exp[i], m_man[i]};
      if (i != i1 && k < k2) k2 = k;
    end
    return {k1, k2, IDX_W'(i1), sp, sv};
  endfunction

  // scoreboard monitor: compare on the first cycle of each result
  always @(negedge clk) begin
    if (bus.out_valid && !prev_v) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected got=%h required=none", got_result());
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if (got_result() !== e) begin
          bad++;
          $display("FAIL result got=%h required=%h", got_result(), e);
        end
      end
    end
    prev_v = bus.out_valid;
  end

  // driver: feed nbeats messages from m_*; optional idle cycle before each
  task automatic run_node(input int nbeats, input bit gap, input bit push);
    if (push) begin
      last_exp = model();
      exp_q.push_back(last_exp);
    end
    for (int i = 0; i < nbeats; i++) begin
      if (gap) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++; $display("FAIL gap_early_valid got=%b required=0", bus.out_valid);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_sign  = m_sign[i];
      bus.in_exp   = m_exp[i];
      bus.in_man   = m_man[i];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sign  = 1'($urandom_range(0, 1));
      bus.in_exp   = EXP_W'($urandom_range(2, 7));
      bus.in_man   = MAN_W'($urandom_range(0, 1023));
      total++;
      if (i == DEG - 1) begin
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
          bad++; $display("FAIL latency got_v=%b got_r=%b required=1/0", bus.out_valid, bus.in_ready);
        end
      end else if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL early_valid beat=%0d got=%b required=0", i, bus.out_valid);
      end
    end
  endtask

  // driver: accept the held result with one out_ready cycle
  task automatic release_node();
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL ready_during_accept got=%b required=0", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL after_accept got_v=%b got_r=%b required=0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic check_cleared(input string name);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== 1'b0 ||
        got_result() !== '0) begin
      bad++;
      $display("FAIL %s got_v=%b got_r=%b st=%b res=%h required=0/1/0/0",
               name, bus.out_valid, bus.in_ready, dbg_state, got_result());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_cleared("reset_state");
  endtask

  task automatic test_mixed();
    m_exp  = '{4, 3, 5, 3, 6, 2};
    m_man  = '{600, 700, 512, 520, 900, 1000};
    m_sign = '{1, 0, 1, 1, 0, 0};
    run_node(DEG, 1'b0, 1'b1);
    total++;
    if (last_exp !== {7'd2, 10'd1000, 7'd3, 10'd520, 3'd5, 1'b1, 6'b001101}) begin
      bad++; $display("FAIL model_vector got=%h", last_exp);
    end
    release_node();
  endtask

  task automatic test_all_equal();
    for (int i = 0; i < DEG; i++) begin m_exp[i] = 3; m_man[i] = 800; m_sign[i] = 0; end
    run_node(DEG, 1'b0, 1'b1);
    release_node();
  endtask

  task automatic test_min_edge0();
    for (int i = 0; i < DEG; i++) begin m_exp[i] = 7; m_man[i] = 1023; m_sign[i] = i[0]; end
    m_exp[0] = 2; m_man[0] = 5;
    run_node(DEG, 1'b0, 1'b1);
    release_node();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < DEG; i++) begin
      m_exp[i] = EXP_W'($urandom_range(2, 7)); m_man[i] = MAN_W'($urandom_range(0, 1023));
      m_sign[i] = 1'($urandom_range(0, 1));
    end
    run_node(DEG, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'(c % 2);
      bus.in_exp   = 2;
      bus.in_man   = 0;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || got_result() !== last_exp) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got_v=%b got_r=%b res=%h required=1/0/%h",
                 c, bus.out_valid, bus.in_ready, got_result(), last_exp);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    release_node();
    // next node straight after the accept, starting from edge 0
    m_exp  = '{5, 4, 4, 6, 7, 3};
    m_man  = '{10, 20, 20, 0, 0, 999};
    m_sign = '{0, 1, 1, 0, 1, 1};
    run_node(DEG, 1'b0, 1'b1);
    release_node();
  endtask

  task automatic test_gapped();
    m_exp  = '{4, 3, 5, 3, 6, 2};
    m_man  = '{600, 700, 512, 520, 900, 1000};
    m_sign = '{1, 0, 1, 1, 0, 0};
    run_node(DEG, 1'b1, 1'b1);
    release_node();
  endtask

  task automatic test_reset_mid_node();
    for (int i = 0; i < DEG; i++) begin m_exp[i] = 2; m_man[i] = MAN_W'(i); m_sign[i] = 1; end
    run_node(3, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cleared("reset_mid_node");
    for (int i = 0; i < DEG; i++) begin
      m_exp[i] = EXP_W'(7 - i % 3); m_man[i] = MAN_W'(100 * i + 7); m_sign[i] = 1'(i == 4);
    end
    run_node(DEG, 1'b0, 1'b1);
    release_node();
  endtask

  task automatic test_reset_in_hold();
    for (int i = 0; i < DEG; i++) begin
      m_exp[i] = EXP_W'($urandom_range(2, 7)); m_man[i] = MAN_W'($urandom_range(0, 1023));
      m_sign[i] = 1'($urandom_range(0, 1));
    end
    run_node(DEG, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cleared("reset_in_hold");
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < DEG; i++) begin
        m_exp[i] = EXP_W'($urandom_range(2, 7)); m_man[i] = MAN_W'($urandom_range(0, 1023));
        m_sign[i] = 1'($urandom_range(0, 1));
      end
      if (t % 3 == 0) m_man[t % DEG] = m_man[(t + 1) % DEG];
      if (t % 3 == 0) m_exp[t % DEG] = m_exp[(t + 1) % DEG];
      run_node(DEG, 1'($urandom_range(0, 1)), 1'b1);
      release_node();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_man    = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;

    test_reset();
    test_mixed();
    test_all_equal();
    test_min_edge0();
    test_backpressure();
    test_gapped();
    test_reset_mid_node();
    test_reset_in_hold();
    test_random(20);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover_results got=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
